nibble_add_seq: RTL and testbench
=================================

NIBBLE_ADD_SEQ -- requirements
Module: nibble_add_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/sum width in bits; legal values are multiples of 4 in the range 4..32.
REQ-002 SHALL have ports clk, input, 1, the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1, request to begin one addition.
REQ-005 SHALL have ports a and b, input, WIDTH each, operands; sampled only when start is accepted.
REQ-006 SHALL have port ci, input, 1, carry-in; sampled only when start is accepted.
REQ-007 SHALL have port busy, output, 1, high while an addition is in progress.
REQ-008 SHALL have port done, output, 1, single-cycle pulse marking a valid result.
REQ-009 SHALL have port s, output, WIDTH, registered sum.
REQ-010 SHALL have port co, output, 1, registered carry-out of the MSB nibble.

Function
REQ-011 SHALL compute {co,s} = a + b + ci (unsigned) using one shared 4-bit adder, one nibble per cycle, LSB nibble first.
REQ-012 SHALL implement FSM states IDLE, RUN, DONE.
REQ-013 IDLE: start=1 at an edge SHALL latch a, b, ci, clear the nibble counter, and enter RUN; start=0 SHALL keep IDLE.
REQ-014 RUN: each cycle SHALL add nibble[i] of a and b with the carry register, write the 4-bit result into s[4i+3:4i], update the carry register, and increment i.
REQ-015 RUN SHALL last exactly N = WIDTH/4 cycles; on the edge writing nibble N-1 SHALL enter DONE and load co from the final carry.
REQ-016 DONE: SHALL last one cycle with done=1, then enter IDLE; if start=1 in DONE, SHALL accept it exactly as in IDLE, entering RUN directly (back-to-back operation).
REQ-017 busy SHALL be 1 exactly in RUN; done SHALL be 1 exactly in DONE; the two are never high together.
REQ-018 Latency: start accepted at edge k SHALL give done=1 in the cycle after edge k+N, e.g. edge k+4 for WIDTH=16.
REQ-019 start in RUN SHALL be ignored: no restart, no operand re-latch, no lost cycle.
REQ-020 Operand changes on a, b, ci after acceptance SHALL NOT affect the in-flight result.
REQ-021 s and co SHALL hold the last completed result from DONE until the next acceptance; during RUN, s bits above the current nibble SHALL retain prior values and are not valid.
REQ-022 Overflow SHALL wrap modulo 2^WIDTH with the carry reported on co; no saturation.
REQ-023 The nibble counter SHALL be ceil(log2(N)) bits minimum and SHALL NOT wrap during a valid operation.

Reset
REQ-024 rst_n=0 SHALL asynchronously force state=IDLE, busy=0, done=0, s=0, co=0, carry register=0, and counter=0.
REQ-025 Reset during RUN SHALL abort the operation with no done pulse; the first start after rst_n rises SHALL be handled normally.
REQ-026 Release of rst_n SHALL NOT by itself start an operation.

Structure
REQ-027 A shared package or include SHALL hold the FSM state encodings (2-bit: IDLE=0, RUN=1, DONE=2) and the constant NIBBLE_W=4.
REQ-028 SHALL instantiate one sub-module fa4 (4-bit ripple adder; ports s, co, a, b, ci) as the only arithmetic resource.
REQ-029 Nibble selection SHALL be by counter-indexed part-select or mux; no WIDTH-wide adder SHALL be inferred.

Verification
REQ-030 WIDTH=16; a=0x1234, b=0x4321, ci=0, start one cycle -> busy high 4 cycles, then done=1 for 1 cycle, s=0x5555, co=0.
REQ-031 a=0xFFFF, b=0x0001, ci=0 -> s=0x0000, co=1; also a=0xFFFF, b=0x0000, ci=1 -> s=0x0000, co=1.
REQ-032 start held high continuously with a=0x0F0F, b=0x00F1 -> start ignored in RUN, result s=0x1000, co=0, and a new operation starts from DONE with no IDLE cycle.
REQ-033 rst_n pulsed low in the 2nd RUN cycle -> busy=0, done never pulses, s=0, co=0; the next start with a=0x0001, b=0x0001 -> s=0x0002.
REQ-034 1000 random {ci,a,b} with operands changed immediately after acceptance -> every done matches the reference model a+b+ci computed from the latched values.

Source files
------------

// File: rtl/nibble_add_seq_pkg.sv
// Shared definitions for the nibble-serial adder: FSM encoding and nibble width.
package nibble_add_seq_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/fa4.sv
// 4-bit ripple-carry adder; the only arithmetic resource of nibble_add_seq.
module fa4
    import nibble_add_seq_pkg::*;
(
    output logic [NIBBLE_W-1:0] s,
    output logic                co,
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                ci
);

    always_comb begin
        logic [NIBBLE_W:0] c;
        c    = '0;
        s    = '0;
        c[0] = ci;
        for (int i = 0; i < NIBBLE_W; i++) begin
            s[i]     = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        co = c[NIBBLE_W];
    end

endmodule

// File: rtl/nibble_add_seq.sv
// Sequential adder: {co,s} = a + b + ci, one nibble per cycle through a shared fa4.
// Handshake: start is accepted on a rising edge while in IDLE or DONE; done pulses one cycle per result.
module nibble_add_seq
    import nibble_add_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output state_t           state
);

    localparam int N  = WIDTH / NIBBLE_W;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t                state_next;
    logic [WIDTH-1:0]      a_q;
    logic [WIDTH-1:0]      b_q;
    logic                  carry;
    logic [CW-1:0]         idx;
    logic [NIBBLE_W-1:0]   a_nib;
    logic [NIBBLE_W-1:0]   b_nib;
    logic [NIBBLE_W-1:0]   sum_nib;
    logic                  sum_co;
    logic                  accept;

    // Acceptance is identical in IDLE and DONE, which gives back-to-back operation.
    assign accept = start && (state == IDLE || state == DONE);
    assign busy   = (state == RUN);
    assign done   = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (idx == LAST) state_next = DONE;
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        a_nib = '0;
        b_nib = '0;
        for (int k = 0; k < N; k++) begin
            if (idx == CW'(k)) begin
                a_nib = a_q[k*NIBBLE_W +: NIBBLE_W];
                b_nib = b_q[k*NIBBLE_W +: NIBBLE_W];
            end
        end
    end

    fa4 u_fa4 (
        .s  (sum_nib),
        .co (sum_co),
        .a  (a_nib),
        .b  (b_nib),
        .ci (carry)
    );

    // s is only overwritten nibble by nibble in RUN, so it holds the last result otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            carry <= 1'b0;
            idx   <= '0;
            s     <= '0;
            co    <= 1'b0;
        end else if (accept) begin
            a_q   <= a;
            b_q   <= b;
            carry <= ci;
            idx   <= '0;
        end else if (state == RUN) begin
            for (int k = 0; k < N; k++) begin
                if (idx == CW'(k)) begin
                    s[k*NIBBLE_W +: NIBBLE_W] <= sum_nib;
                end
            end
            carry <= sum_co;
            if (idx == LAST) begin
                co <= sum_co;
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_nibble_add_seq.sv
// Self-checking bench for nibble_add_seq: directed cases plus randomized operations against a behavioural model.
module tb_nibble_add_seq;
    import nibble_add_seq_pkg::*;

    localparam int W = 16;
    localparam int N = W / 4;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         ci    = 1'b0;
    logic         busy;
    logic         done;
    logic         co;
    logic [W-1:0] s;
    state_t       state;

    int checks   = 0;
    int failures = 0;
    bit rand_start_en = 1'b0;

    always #5 clk = ~clk;

    nibble_add_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .ci    (ci),
        .busy  (busy),
        .done  (done),
        .s     (s),
        .co    (co),
        .state (state)
    );

    task automatic check(input string name, input logic [W:0] act, input logic [W:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: an accepted request yields a+b+ci after N busy cycles, then one done cycle.
    int           m_left = 0;
    logic         m_done = 1'b0;
    logic [W-1:0] m_s    = '0;
    logic         m_co   = 1'b0;
    logic [W:0]   m_res  = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left <= 0;
            m_done <= 1'b0;
            m_s    <= '0;
            m_co   <= 1'b0;
        end else if (m_left != 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_done       <= 1'b1;
                {m_co, m_s}  <= m_res;
            end
        end else begin
            m_done <= 1'b0;
            if (start) begin
                m_res  <= (W+1)'(a) + (W+1)'(b) + (W+1)'(ci);
                m_left <= N;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("busy", {{W{1'b0}}, busy}, {{W{1'b0}}, m_left != 0});
            check("done", {{W{1'b0}}, done}, {{W{1'b0}}, m_done});
            check("state", (W+1)'(state),
                  (m_left != 0) ? (W+1)'(1) : (m_done ? (W+1)'(2) : (W+1)'(0)));
            if (m_left == 0) begin
                check("sum", {co, s}, {m_co, m_s});
            end
        end
    end

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tci,
                          input logic [W:0] exp, input string name);
        int busy_cnt;
        int lat;
        bit got;
        @(negedge clk);
        #1;
        a = ta; b = tb; ci = tci; start = 1'b1;
        @(negedge clk);
        busy_cnt = busy ? 1 : 0;
        #1;
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        ci = 1'($urandom_range(0, 1));
        lat = 0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            lat++;
            if (done) begin
                got = 1'b1;
                check({name, "_result"}, {co, s}, exp);
            end else begin
                busy_cnt += busy ? 1 : 0;
                if (rand_start_en) begin
                    #1;
                    start = 1'($urandom_range(0, 1));
                end
            end
        end
        #1;
        start = 1'b0;
        check({name, "_done_seen"}, (W+1)'(got), (W+1)'(1));
        check({name, "_latency"}, (W+1)'(lat), (W+1)'(N));
        check({name, "_busy_len"}, (W+1)'(busy_cnt), (W+1)'(N));
    endtask

    task automatic wait_done(input string name, output bit got);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (done) got = 1'b1;
        end
        check({name, "_done_seen"}, (W+1)'(got), (W+1)'(1));
    endtask

    initial begin
        bit got;
        int done_cnt;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic rc;

        #1 rst_n = 1'b0;
        #2;
        check("reset_busy", (W+1)'(busy), '0);
        check("reset_done", (W+1)'(done), '0);
        check("reset_sum", {co, s}, '0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("no_self_start", (W+1)'(busy), '0);

        run_op(16'h1234, 16'h4321, 1'b0, {1'b0, 16'h5555}, "basic");
        run_op(16'hFFFF, 16'h0001, 1'b0, {1'b1, 16'h0000}, "wrap_b");
        run_op(16'hFFFF, 16'h0000, 1'b1, {1'b1, 16'h0000}, "wrap_ci");
        run_op(16'h0000, 16'h0000, 1'b0, {1'b0, 16'h0000}, "zero");
        run_op(16'h8000, 16'h8000, 1'b1, {1'b1, 16'h0001}, "msb_carry");

        // start held high: ignored in RUN, re-accepted straight out of DONE.
        @(negedge clk);
        #1;
        a = 16'h0F0F; b = 16'h00F1; ci = 1'b0; start = 1'b1;
        wait_done("b2b_first", got);
        check("b2b_first_result", {co, s}, {1'b0, 16'h1000});
        @(negedge clk);
        check("b2b_no_idle_busy", (W+1)'(busy), (W+1)'(1));
        check("b2b_no_idle_done", (W+1)'(done), '0);
        #1 start = 1'b0;
        wait_done("b2b_second", got);
        check("b2b_second_result", {co, s}, {1'b0, 16'h1000});
        repeat (2) @(negedge clk);

        // Reset asserted in the second RUN cycle aborts the operation.
        #1;
        a = 16'hABCD; b = 16'h1111; ci = 1'b1; start = 1'b1;
        @(negedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check("abort_in_run", (W+1)'(busy), (W+1)'(1));
        #1 rst_n = 1'b0;
        #1;
        check("abort_busy", (W+1)'(busy), '0);
        check("abort_done", (W+1)'(done), '0);
        check("abort_sum", {co, s}, '0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check("abort_no_done", (W+1)'(done_cnt), '0);
        run_op(16'h0001, 16'h0001, 1'b0, {1'b0, 16'h0002}, "after_reset");

        rand_start_en = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom_range(0, 1));
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_op(ra, rb, rc, (W+1)'(ra) + (W+1)'(rb) + (W+1)'(rc), "random");
        end
        rand_start_en = 1'b0;
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
